// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end with a prefetch queue. Owns the PC, issues one
// read per cycle to a synchronous (1-cycle latency) instruction ROM and buffers
// the returned instructions, tagged with their PCs, in a DEPTH-entry FIFO that
// feeds decode through a valid/ready handshake. A redirect flushes the queue
// and kills the read in flight.
//
// Build option: define FQ_JAL_PREDICT_EN to enable static JAL prediction
// (returned JAL retargets the PC, the wrong-path read is killed, the entry is
// tagged pred=1). Undefined: purely sequential fetch, o_if_pred tied low.
//
// Ports
//   i_clk, i_rst_n      clock; synchronous active-low reset
//   i_pll_lock          fetch permitted only while high
//   o_imem_req/addr     ROM read strobe and byte address
//   i_imem_rdata        ROM data, valid the cycle after o_imem_req
//   i_redirect/_pc      flush queue and restart fetch at i_redirect_pc
//   o_if_valid          queue head valid (gated low during a redirect)
//   i_id_ready          decode accepts head
//   o_if_instr/pc/pred  head instruction, its PC, predicted-taken tag
//   o_count             queue occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pll_lock,
  output logic                     o_imem_req,
  output logic [XLEN-1:0]          o_imem_addr,
  input  logic [31:0]              i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_if_valid,
  input  logic                     i_id_ready,
  output logic [31:0]              o_if_instr,
  output logic [XLEN-1:0]          o_if_pc,
  output logic                     o_if_pred,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];

  logic            w_if_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_jal_take;
  logic [CW:0]     w_occupancy;
  logic [XLEN-1:0] w_pc_next;

  // Head is only presented when the queue holds something and no flush is
  // happening this cycle; a redirect voids the handshake.
  assign w_if_valid = (r_count != '0) & ~i_redirect;
  assign w_pop      = w_if_valid & i_id_ready;
  // A response that arrives in a redirect cycle belongs to the flushed path.
  assign w_push     = r_inflight & ~i_redirect;

  // Occupancy after this cycle's pop plus the response still owed: issuing
  // only when that is below DEPTH guarantees every response has a free slot.
  assign w_occupancy = {1'b0, r_count} - (CW+1)'(w_pop) + (CW+1)'(r_inflight);
  assign w_issue     = i_rst_n & i_pll_lock & ~i_redirect
                     & (w_occupancy < (CW+1)'(DEPTH));

`ifdef FQ_JAL_PREDICT_EN
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_jal_target;
  logic            r_q_pred [DEPTH];

  assign w_imm_j      = {{(XLEN-20){i_imem_rdata[31]}}, i_imem_rdata[19:12],
                         i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
  assign w_jal_take   = w_push & (i_imem_rdata[6:0] == 7'b1101111);
  assign w_jal_target = r_inflight_pc + w_imm_j;
  assign o_if_pred    = r_q_pred[r_head];
`else
  assign w_jal_take   = 1'b0;
  assign o_if_pred    = 1'b0;
`endif

  // Next PC priority: redirect > JAL target > sequential advance > hold.
  always_comb begin
    // NOTE: default first so every path assigns w_pc_next and no latch is inferred.
    w_pc_next = r_pc;
    if (w_issue)    w_pc_next = r_pc + XLEN'(4);
`ifdef FQ_JAL_PREDICT_EN
    if (w_jal_take) w_pc_next = w_jal_target;
`endif
    if (i_redirect) w_pc_next = i_redirect_pc;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      // NOTE: the queue storage is reset too, because the head outputs read it
      // directly and must show zero after reset; it is only DEPTH registers.
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
`ifdef FQ_JAL_PREDICT_EN
        r_q_pred[i]  <= 1'b0;
`endif
      end
    end else begin
      r_pc <= w_pc_next;
      // A read issued alongside a taken JAL fetches the fall-through path.
      r_inflight <= w_issue & ~w_jal_take;
      if (w_issue) r_inflight_pc <= r_pc;

      if (i_redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_q_instr[r_tail] <= i_imem_rdata;
          r_q_pc[r_tail]    <= r_inflight_pc;
`ifdef FQ_JAL_PREDICT_EN
          r_q_pred[r_tail]  <= w_jal_take;
`endif
          r_tail <= r_tail + AW'(1);
        end
        if (w_pop) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_pc;
  assign o_if_valid  = w_if_valid;
  assign o_if_instr  = r_q_instr[r_head];
  assign o_if_pc     = r_q_pc[r_head];
  assign o_count     = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed bench for fetch_queue_unit. A behavioural ROM answers each request
// one cycle later with addr ^ 32'h5A5A_0000 (never a JAL opcode), except that
// in JAL mode address 0x00400008 holds "jal x0, +16". A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] JAL16  = 32'h0100_006F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock, redirect, ready;
  logic [31:0] redirect_pc;
  logic        imem_req, if_valid, if_pred;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
  logic [2:0]  count;

  logic        rst_n_w, redirect_w, ready_w;
  logic [31:0] redirect_pc_w;
  logic        imem_req_w, if_valid_w, if_pred_w;
  logic [31:0] imem_addr_w, imem_rdata_w, if_instr_w, if_pc_w;
  logic [2:0]  count_w;

  int          errors = 0;
  int          checks = 0;
  logic        jal_mode = 1'b0;
  logic [31:0] exp_pc;

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(lock),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_if_valid(if_valid), .i_id_ready(ready), .o_if_instr(if_instr),
    .o_if_pc(if_pc), .o_if_pred(if_pred), .o_count(count));

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n_w), .i_pll_lock(lock),
    .o_imem_req(imem_req_w), .o_imem_addr(imem_addr_w), .i_imem_rdata(imem_rdata_w),
    .i_redirect(redirect_w), .i_redirect_pc(redirect_pc_w),
    .o_if_valid(if_valid_w), .i_id_ready(ready_w), .o_if_instr(if_instr_w),
    .o_if_pc(if_pc_w), .o_if_pred(if_pred_w), .o_count(count_w));

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (jal_mode && a == 32'h0040_0008) return JAL16;
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    imem_rdata   = '0;
    imem_rdata_w = '0;
  end
  always @(posedge clk) if (imem_req)   imem_rdata   <= rom_word(imem_addr);
  always @(posedge clk) if (imem_req_w) imem_rdata_w <= rom_word(imem_addr_w);

  // Overflow can never happen by construction; watch for it every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (count > 3'(DEPTH)) begin
        errors++;
        $display("FAIL overflow: count=%0d exceeds %0d", count, DEPTH);
      end
    end
  end

  task automatic test_reset;
    rst_n = 0; lock = 1; ready = 1; redirect = 0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    checks++; if (if_pred !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", if_pred); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL first_addr: got %h want %h", imem_addr, RST_PC); end
    exp_pc = RST_PC;
  endtask

  task automatic test_stream;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: valid=%b want 0 one cycle after first req", if_valid); end
      end else begin
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b want 1", k, if_valid); end
        checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d: got %h want %h", k, if_pc, exp_pc); end
        checks++; if (if_instr !== rom_word(exp_pc)) begin errors++; $display("FAIL stream_instr k=%0d: got %h want %h", k, if_instr, rom_word(exp_pc)); end
        checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count k=%0d: got %0d want <=1", k, count); end
      end
      if (if_valid && ready) exp_pc += 4;
    end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ready = 0;
      #1;
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d want 4", count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0 while full", imem_req); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ready = 1;
      #1;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d: got %b want 1", k, if_valid); end
      checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL bp_pc k=%0d: got %h want %h", k, if_pc, exp_pc); end
      checks++; if (if_instr !== rom_word(exp_pc)) begin errors++; $display("FAIL bp_instr k=%0d: got %h want %h", k, if_instr, rom_word(exp_pc)); end
      if (if_valid && ready) exp_pc += 4;
    end
  endtask

  task automatic test_redirect;
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ready = 0;
      #1;
      if (count == 3'd3) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_setup: count=%0d never reached 3", count); end
    redirect = 1; redirect_pc = 32'h0040_0100; ready = 1;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_gate: valid=%b want 0", if_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noreq: req=%b want 0", imem_req); end
    @(negedge clk);
    redirect = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_flush: count=%0d want 0", count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL redir_req: req=%b addr=%h want 1 00400100", imem_req, imem_addr); end
    @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_t2_valid: got %b want 0", if_valid); end
    exp_pc = 32'h0040_0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin errors++; $display("FAIL redir_seq k=%0d: valid=%b pc=%h want 1 %h", k, if_valid, if_pc, exp_pc); end
      if (if_valid && ready) exp_pc += 4;
    end
  endtask

  task automatic test_redirect_hold;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      redirect = 1; redirect_pc = 32'h0040_0200;
      #1;
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_gate k=%0d: valid=%b req=%b want 0 0", k, if_valid, imem_req); end
      if (k > 0) begin
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL hold_empty k=%0d: count=%0d want 0", k, count); end
      end
    end
    @(negedge clk);
    redirect = 0;
    #1;
    checks++; if (imem_addr !== 32'h0040_0200 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_req: req=%b addr=%h want 1 00400200", imem_req, imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0200) begin errors++; $display("FAIL hold_pc: valid=%b pc=%h want 1 00400200", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ready = 0;
      #1;
      if (count == 3'd4) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_setup: count=%0d never reached 4", count); end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    checks++; if (count !== 3'd0 || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmid_state: count=%0d valid=%b req=%b want 0 0 0", count, if_valid, imem_req); end
    rst_n = 1; ready = 1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL rmid_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== rom_word(RST_PC)) begin errors++; $display("FAIL rmid_first: valid=%b pc=%h instr=%h want 1 %h %h", if_valid, if_pc, if_instr, RST_PC, rom_word(RST_PC)); end
  endtask

  task automatic test_jal;
    logic [31:0] want_pc [5];
    logic        want_pred [5];
    int          n = 0;
`ifdef FQ_JAL_PREDICT_EN
    want_pc   = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_0018, 32'h0040_001C};
    want_pred = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    want_pc   = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010};
    want_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(negedge clk);
    rst_n = 0; jal_mode = 1;
    @(negedge clk);
    rst_n = 1; ready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (if_valid && ready && n < 5) begin
        checks++; if (if_pc !== want_pc[n] || if_pred !== want_pred[n]) begin errors++; $display("FAIL jal_seq n=%0d: pc=%h pred=%b want %h %b", n, if_pc, if_pred, want_pc[n], want_pred[n]); end
        checks++; if (if_instr !== rom_word(want_pc[n])) begin errors++; $display("FAIL jal_instr n=%0d: got %h want %h", n, if_instr, rom_word(want_pc[n])); end
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL jal_count: delivered %0d want 5", n); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rst_n_w = 1;
    #1;
    checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: req=%b addr=%h want 1 fffffffc", imem_req_w, imem_addr_w); end
    @(negedge clk);
    #1;
    checks++; if (imem_addr_w !== 32'h0000_0000) begin errors++; $display("FAIL wrap_second: addr=%h want 00000000", imem_addr_w); end
    @(negedge clk);
    #1;
    checks++; if (if_valid_w !== 1'b1 || if_pc_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head0: valid=%b pc=%h want 1 fffffffc", if_valid_w, if_pc_w); end
    @(negedge clk);
    #1;
    checks++; if (if_valid_w !== 1'b1 || if_pc_w !== 32'h0000_0000) begin errors++; $display("FAIL wrap_head1: valid=%b pc=%h want 1 00000000", if_valid_w, if_pc_w); end
  endtask

  initial begin
    rst_n_w = 0; redirect_w = 0; redirect_pc_w = '0; ready_w = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_hold();
    test_reset_mid();
    test_jal();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
